// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
//
// Purpose: bundles the field-input handshake and the encoded-word output
//          handshake of instr_encoder into one interface.
//
// Signals:
//   in_valid / in_ready        field bundle handshake (producer -> encoder)
//   in_fmt                     0=R 1=I 2=S 3=B 4=U 5=J 6=SH 7=IU
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                              decoded instruction fields
//   out_valid / out_ready      encoded word handshake (encoder -> consumer)
//   out_instr                  packed 32-bit instruction word
//   out_addr                   byte address of out_instr (ADDR_W bits)
//   out_err                    head word failed its immediate range check
//   err_count                  saturating count of accepted erroring words
//
// Modports:
//   master  producer/consumer side (program loader, testbench)
//   slave   encoder side
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [7:0]        err_count;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose: streaming RV32I instruction encoder, the inverse of the core's
//          immediate generation. Scatters the immediate into its RV32I bit
//          positions, optionally range-checks it, tags each word with a
//          sequential byte address and buffers it in a 2-entry FIFO.
//
// Parameters:
//   ADDR_W     width of out_addr (byte address)
//   BASE_ADDR  address of the first word after reset or clear
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   clear  synchronous flush: empty FIFO, address := BASE_ADDR, err_count := 0
//   bus    instr_encoder_if.slave (field input and word output handshakes)
//
// Configuration macro:
//   ENC_RANGE_CHECK_EN  defined   -> range checks drive out_err / err_count
//                       undefined -> no check logic, out_err = 0, err_count = 0
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    instr_encoder_if.slave bus
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_SH = 3'd6,
        FMT_IU = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
`ifdef ENC_RANGE_CHECK_EN
        logic              err;
`endif
    } entry_t;

    function automatic entry_t reset_entry();
        entry_t e;
        e      = '0;
        e.addr = BASE;
        return e;
    endfunction

    fmt_e              fmt;
    logic [31:0]       enc_word;
    entry_t            new_entry;
    entry_t            head;
    entry_t            tail;
    fifo_state_e       state;
    fifo_state_e       next_state;
    logic              ready_en;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] addr_cnt;

    assign fmt = fmt_e'(bus.in_fmt);

    // ---------------------------------------------------------------------
    // Field packing
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        enc_word = '0;
        case (fmt)
            FMT_R:         enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                                       bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_I, FMT_IU: enc_word = {bus.in_imm[11:0], bus.in_rs1,
                                       bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_SH:        enc_word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1,
                                       bus.in_funct3, bus.in_rd, bus.in_opcode};
            FMT_S:         enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                                       bus.in_funct3, bus.in_imm[4:0], bus.in_opcode};
            FMT_B:         enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2,
                                       bus.in_rs1, bus.in_funct3, bus.in_imm[4:1],
                                       bus.in_imm[11], bus.in_opcode};
            FMT_U:         enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
            FMT_J:         enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                                       bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // ---------------------------------------------------------------------
    // Immediate range check: the word is still emitted when out of range,
    // only flagged. "All equal" means the bits are a pure sign extension.
    // ---------------------------------------------------------------------
    logic       range_err;
    logic [7:0] err_cnt;

    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
            FMT_IU:       range_err = |bus.in_imm[31:12];
            FMT_SH:       range_err = |bus.in_imm[31:5];
            FMT_B:        range_err = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12]))
                                      || bus.in_imm[0];
            FMT_J:        range_err = !((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20]))
                                      || bus.in_imm[0];
            FMT_U:        range_err = |bus.in_imm[11:0];
            FMT_R:        range_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clear) begin
            err_cnt <= '0;
        end else if (push && range_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.out_err   = head.err;
    assign bus.err_count = err_cnt;
`else
    assign bus.out_err   = 1'b0;
    assign bus.err_count = 8'd0;
`endif

    always_comb begin
        new_entry       = '0;
        new_entry.instr = enc_word;
        new_entry.addr  = addr_cnt;
`ifdef ENC_RANGE_CHECK_EN
        new_entry.err   = range_err;
`endif
    end

    // ---------------------------------------------------------------------
    // Handshakes. in_ready depends only on registered state and clear, never
    // on out_ready. ready_en holds in_ready low until the first edge after
    // reset release.
    // ---------------------------------------------------------------------
    assign bus.in_ready  = ready_en && (state != FULL) && !clear;
    assign bus.out_valid = (state != EMPTY);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // ---------------------------------------------------------------------
    // FIFO occupancy FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            state    <= EMPTY;
            ready_en <= 1'b0;
        end else begin
            state    <= next_state;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (push) next_state = ONE;
                ONE: begin
                    if (push && !pop)      next_state = FULL;
                    else if (pop && !push) next_state = EMPTY;
                end
                FULL:    if (pop) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // FIFO storage and address counter. head is always the delivered entry;
    // tail only holds the second word while FULL.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two entries are reset because out_instr/out_addr have
            // defined reset values; a deep RAM-style FIFO would not be.
            head     <= reset_entry();
            tail     <= reset_entry();
            addr_cnt <= BASE;
        end else if (clear) begin
            addr_cnt <= BASE;
        end else begin
            if (push) begin
                addr_cnt <= addr_cnt + STEP;
            end
            case (state)
                EMPTY: if (push) head <= new_entry;
                ONE: begin
                    if (push && pop) head <= new_entry;
                    else if (push)   tail <= new_entry;
                end
                FULL:  if (pop) head <= tail;
                default: ;
            endcase
        end
    end

    assign bus.out_instr = head.instr;
    assign bus.out_addr  = head.addr;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed-vector bench for instr_encoder. Stimulus pushes the hand-computed
// expected word/address/error into a scoreboard queue on acceptance; a
// monitor pops and compares whenever the DUT delivers a word. Works with and
// without ENC_RANGE_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
    localparam int ADDR_W = 10;

`ifdef ENC_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                n_checks  = 0;
    int                n_fail    = 0;
    int                n_err_acc = 0;
    logic [ADDR_W-1:0] exp_addr  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- monitor ----------------
    logic              hold_q = 1'b0;
    logic [31:0]       hold_instr;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q && bus.out_valid) begin
                check("hold_instr", bus.out_instr, hold_instr);
                check("hold_addr", 32'(bus.out_addr), 32'(hold_addr));
                check("hold_err", 32'(bus.out_err), 32'(hold_err));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%08h at 0x%0h, none expected",
                             bus.out_instr, bus.out_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_instr", bus.out_instr, mon_e.instr);
                    check("out_addr", 32'(bus.out_addr), 32'(mon_e.addr));
                    check("out_err", 32'(bus.out_err), 32'(mon_e.err));
                end
            end
            hold_q     = bus.out_valid && !bus.out_ready;
            hold_instr = bus.out_instr;
            hold_addr  = bus.out_addr;
            hold_err   = bus.out_err;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        bus.in_fmt    = fmt;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    task automatic send(input string name, input logic [2:0] fmt, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic bad);
        bit ok = 1'b0;
        drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                exp_q.push_back('{exp_instr, exp_addr, RANGE_CHK & bad});
                exp_addr = exp_addr + ADDR_W'(4);
                if (bad) n_err_acc++;
            end
            @(posedge clk);
        end
        #1 bus.in_valid = 1'b0;
        if (!ok) fail_now({name, "_accept"});
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !bus.out_valid;
        end
        if (!done) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        check("clear_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        exp_q.delete();
        exp_addr  = '0;
        n_err_acc = 0;
        check("clear_out_valid", 32'(bus.out_valid), 32'd0);
        check("clear_err_count", 32'(bus.err_count), 32'd0);
    endtask

    function automatic logic [7:0] exp_err_count();
        if (!RANGE_CHK) return 8'd0;
        return (n_err_acc > 255) ? 8'hFF : 8'(n_err_acc);
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_addr", 32'(bus.out_addr), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // addi x1, x0, -1 ; latency: head valid right after the accept edge
        send("i_neg1", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        drain();
        clear_pulse();

        // S, B, J, U at addresses 0, 4, 8, 12
        send("s_sw", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
        send("b_m4", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send("j_800", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
        send("u_lui", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        // R and SH
        send("r_add", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h0020_81B3, 1'b0);
        send("sh_srai", 3'd6, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3, 32'h4030_D093, 1'b0);
        send("iu_fff", 3'd7, 7'h13, 5'd1, 5'd2, 5'd0, 3'd3, 7'd0, 32'h0000_0FFF, 32'hFFF1_3093, 1'b0);
        // Range errors: word still emitted with truncated fields
        send("i_2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b1);
        drain();
        check("err_count_one", 32'(bus.err_count), 32'(exp_err_count()));
        send("sh_32", 3'd6, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd32, 32'h4000_D093, 1'b1);
        send("iu_neg", 3'd7, 7'h13, 5'd1, 5'd2, 5'd0, 3'd3, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_3093, 1'b1);
        send("u_low", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
        send("b_odd", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b1);
        drain();
        check("err_count_five", 32'(bus.err_count), 32'(exp_err_count()));
        clear_pulse();

        // Backpressure: two accepts fill the FIFO, then in_ready stays low
        bus.out_ready = 1'b0;
        send("bp_w0", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h0020_81B3, 1'b0);
        send("bp_w1", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3, 1'b0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send("bp_w2", 3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0393, 1'b0);
        drain();
        clear_pulse();

        // clear while FULL with in_valid high: nothing accepted, addr restarts
        bus.out_ready = 1'b0;
        send("cl_w0", 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 32'hABCD_E0B7, 1'b0);
        send("cl_w1", 3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1111_1000, 32'h1111_1137, 1'b0);
        bus.in_valid = 1'b1;
        clear_pulse();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        send("cl_after", 3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h2222_2000, 32'h2222_21B7, 1'b0);
        drain();
        clear_pulse();

        // Address wrap (256 words per lap) and err_count saturation
        for (int i = 0; i < 260; i++) begin
            logic [4:0] rd;
            rd = 5'(i);
            send("wrap", 3'd1, 7'h13, rd, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
                 32'h8000_0013 | (32'(rd) << 7), 1'b1);
        end
        drain();
        check("err_count_sat", 32'(bus.err_count), 32'(exp_err_count()));

        // Asynchronous reset mid-stream drops FIFO contents immediately
        bus.out_ready = 1'b0;
        send("ar_w0", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        check("arst_out_addr", 32'(bus.out_addr), 32'd0);
        check("arst_err_count", 32'(bus.err_count), 32'd0);
        exp_q.delete();
        exp_addr  = '0;
        n_err_acc = 0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send("ar_after", 3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
